// File: rtl/slip_arith_pkg.sv
// Shared definitions for the Slipstream arithmetic blocks.
//   csa_state_t : control states of the chunked serial adder.
//   nchunk()    : number of chunks a WIDTH-bit word splits into.
//   cntWidth()  : bits needed for a chunk counter (at least 1).
//   *_WIDTH     : word widths shared by the blitter arithmetic paths.
package slip_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } csa_state_t;

  localparam int ADDR_WIDTH    = 16;
  localparam int STEP_WIDTH    = 16;
  localparam int DEFAULT_CHUNK = 4;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A one-chunk configuration still needs a 1-bit counter register.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_serial_adder_chunk_full_add.sv
// chunk_full_add: combinational CHUNK-bit ripple adder built from half-adder
// cells (two half adders plus an OR per bit).
//   a, b  in  CHUNK  operand slices
//   cin   in  1      carry into bit 0
//   sum   out CHUNK  sum slice
//   cout  out 1      carry out of the top bit
//   cTop  out 1      carry into the top bit (overflow detection)
module chunk_full_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cTop
);

  logic [CHUNK:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : gBit
      logic halfSum;
      logic halfCarryAb;
      logic halfCarryCin;

      // First half adder: a + b.
      assign halfSum      = a[gi] ^ b[gi];
      assign halfCarryAb  = a[gi] & b[gi];
      // Second half adder: partial sum + incoming carry.
      assign sum[gi]      = halfSum ^ carry[gi];
      assign halfCarryCin = halfSum & carry[gi];
      assign carry[gi+1]  = halfCarryAb | halfCarryCin;
    end
  endgenerate

  assign cout = carry[CHUNK];
  assign cTop = carry[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle WIDTH-bit adder/subtractor that
// processes CHUNK bits per clock, carrying between chunks in a register.
//   MasterClock in  1      clock, rising edge
//   nReset      in  1      asynchronous active-low reset
//   START       in  1      request, accepted in IDLE or FIN
//   A, B        in  WIDTH  operands, latched on accepted START
//   CI          in  1      carry-in (ignored when SUB=1)
//   SUB         in  1      1: A-B, 0: A+B+CI
//   BUSY        out 1      high while chunks are being processed
//   DONE        out 1      single-cycle completion pulse
//   Q           out WIDTH  result, held until the next completion
//   CO          out 1      carry out of MSB (1 = no borrow when subtracting)
//   OV          out 1      signed two's-complement overflow
module chunked_serial_adder
  import slip_arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             MasterClock,
  input  logic             nReset,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             OV
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = cntWidth(NCHUNK);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  generate
    if (WIDTH % CHUNK != 0) begin : gBadCfg
      $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  csa_state_t stateReg, stateNext;

  logic [CW-1:0]    counterReg;
  logic             carryReg;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] sumReg;
  logic [WIDTH-1:0] qReg;
  logic             coReg;
  logic             ovReg;

  logic             accept;
  logic             lastChunk;
  logic [CHUNK-1:0] chunkSum;
  logic             chunkCout;
  logic             chunkCTop;
  logic [WIDTH-1:0] sumMerged;

  // FIN accepts a new request just like IDLE, giving back-to-back operation.
  assign accept    = START && (stateReg == IDLE || stateReg == FIN);
  assign lastChunk = (stateReg == RUN) && (counterReg == LAST_CHUNK);

  chunk_full_add #(
    .CHUNK(CHUNK)
  ) uAdd (
    .a   (aReg[int'(counterReg)*CHUNK +: CHUNK]),
    .b   (bReg[int'(counterReg)*CHUNK +: CHUNK]),
    .cin (carryReg),
    .sum (chunkSum),
    .cout(chunkCout),
    .cTop(chunkCTop)
  );

  // Partial sum with the current chunk merged in; on the last chunk this is
  // the complete result, so Q can load it on the edge entering FIN.
  always_comb begin
    sumMerged = sumReg;
    sumMerged[int'(counterReg)*CHUNK +: CHUNK] = chunkSum;
  end

  // State register
  always_ff @(posedge MasterClock or negedge nReset) begin
    if (!nReset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    stateNext = accept ? RUN : IDLE;
      RUN:     stateNext = lastChunk ? FIN : RUN;
      FIN:     stateNext = accept ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    case (stateReg)
      RUN:     BUSY = 1'b1;
      FIN:     DONE = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge MasterClock or negedge nReset) begin
    if (!nReset) begin
      counterReg <= '0;
      carryReg   <= 1'b0;
      aReg       <= '0;
      bReg       <= '0;
      sumReg     <= '0;
      qReg       <= '0;
      coReg      <= 1'b0;
      ovReg      <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1, so the inverted operand and forced carry
      // are captured here and the chunk loop only ever adds.
      aReg       <= A;
      bReg       <= SUB ? ~B : B;
      carryReg   <= SUB ? 1'b1 : CI;
      counterReg <= '0;
    end else if (stateReg == RUN) begin
      sumReg   <= sumMerged;
      carryReg <= chunkCout;
      if (lastChunk) begin
        qReg  <= sumMerged;
        coReg <= chunkCout;
        ovReg <= chunkCout ^ chunkCTop;
      end else begin
        counterReg <= counterReg + CW'(1);
      end
    end
  end

  assign Q  = qReg;
  assign CO = coReg;
  assign OV = ovReg;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop and compare
// whenever a DUT raises DONE. Two instances: CHUNK=4 and CHUNK=WIDTH.
module tb_chunked_serial_adder;

  typedef struct {
    logic [15:0] q;
    logic        co;
    logic        ov;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic nReset = 1'b0;

  logic        start1 = 1'b0, ci1 = 1'b0, sub1 = 1'b0;
  logic [15:0] a1 = '0, b1 = '0;
  logic        busy1, done1, co1, ov1;
  logic [15:0] q1;

  logic        start2 = 1'b0, ci2 = 1'b0, sub2 = 1'b0;
  logic [15:0] a2 = '0, b2 = '0;
  logic        busy2, done2, co2, ov2;
  logic [15:0] q2;

  exp_t sb1[$];
  exp_t sb2[$];
  exp_t e1, e2;

  int total = 0;
  int bad = 0;
  int cycleCount = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut1 (
    .MasterClock(clk), .nReset(nReset), .START(start1), .A(a1), .B(b1),
    .CI(ci1), .SUB(sub1), .BUSY(busy1), .DONE(done1), .Q(q1), .CO(co1), .OV(ov1)
  );

  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut2 (
    .MasterClock(clk), .nReset(nReset), .START(start2), .A(a2), .B(b2),
    .CI(ci2), .SUB(sub2), .BUSY(busy2), .DONE(done2), .Q(q2), .CO(co2), .OV(ov2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (sb1.size() == 0) begin
        check("dut1 unexpected DONE", 32'd1, 32'd0);
      end else begin
        e1 = sb1.pop_front();
        check({e1.name, " Q"}, 32'(q1), 32'(e1.q));
        check({e1.name, " CO"}, 32'(co1), 32'(e1.co));
        check({e1.name, " OV"}, 32'(ov1), 32'(e1.ov));
        check({e1.name, " DONE cycle"}, 32'(cycleCount), 32'(e1.cyc));
        $display("dut1 %s: Q=%04h CO=%0b OV=%0b cycle=%0d", e1.name, q1, co1, ov1, cycleCount);
      end
    end
  end

  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      if (sb2.size() == 0) begin
        check("dut2 unexpected DONE", 32'd1, 32'd0);
      end else begin
        e2 = sb2.pop_front();
        check({e2.name, " Q"}, 32'(q2), 32'(e2.q));
        check({e2.name, " CO"}, 32'(co2), 32'(e2.co));
        check({e2.name, " OV"}, 32'(ov2), 32'(e2.ov));
        check({e2.name, " DONE cycle"}, 32'(cycleCount), 32'(e2.cyc));
        $display("dut2 %s: Q=%04h CO=%0b OV=%0b cycle=%0d", e2.name, q2, co2, ov2, cycleCount);
      end
    end
  end

  // DONE is expected NCHUNK+1 clock edges after the negedge START is driven.
  task automatic issue1(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sub,
                        input logic [15:0] eq, input logic eco, input logic eov);
    @(negedge clk);
    a1 = a; b1 = b; ci1 = ci; sub1 = sub; start1 = 1'b1;
    sb1.push_back('{q: eq, co: eco, ov: eov, cyc: cycleCount + 5, name: name});
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic issue2(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sub,
                        input logic [15:0] eq, input logic eco, input logic eov);
    @(negedge clk);
    a2 = a; b2 = b; ci2 = ci; sub2 = sub; start2 = 1'b1;
    sb2.push_back('{q: eq, co: eco, ov: eov, cyc: cycleCount + 2, name: name});
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 40 && (sb1.size() != 0 || sb2.size() != 0); i++) @(negedge clk);
    if (sb1.size() != 0 || sb2.size() != 0) begin
      check("DONE timeout (pending results)", 32'(sb1.size() + sb2.size()), 32'd0);
      sb1.delete();
      sb2.delete();
    end
  endtask

  initial begin
    #1;
    check("reset Q", 32'(q1), 32'd0);
    check("reset CO", 32'(co1), 32'd0);
    check("reset OV", 32'(ov1), 32'd0);
    check("reset BUSY", 32'(busy1), 32'd0);
    check("reset DONE", 32'(done1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    nReset = 1'b1;

    // Add, no carry: also confirm BUSY in the first RUN cycle
    issue1("add 00FF+0001", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    check("BUSY during RUN", 32'(busy1), 32'd1);
    waitIdle();
    issue1("wrap FFFF+0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    waitIdle();
    issue1("add 7FFF+0+CI", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    waitIdle();
    issue1("sub 8000-0001", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    waitIdle();
    issue1("sub 0005-0003", 16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    waitIdle();
    issue1("sub 0003-0005", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    waitIdle();
    issue1("add 8000+8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    waitIdle();

    // Handshake: START during RUN ignored, START held in FIN accepted
    issue1("hs first", 16'h0011, 16'h0022, 1'b0, 1'b0, 16'h0033, 1'b0, 1'b0);
    a1 = 16'hAAAA; b1 = 16'h5555; sub1 = 1'b1; ci1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start1 = 1'b0;
    begin
      int n;
      n = 0;
      while (done1 !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (done1 !== 1'b1) check("hs DONE timeout", 32'(done1), 32'd1);
    end
    a1 = 16'h0002; b1 = 16'h0003; ci1 = 1'b0; sub1 = 1'b0; start1 = 1'b1;
    sb1.push_back('{q: 16'h0005, co: 1'b0, ov: 1'b0, cyc: cycleCount + 5, name: "hs back-to-back"});
    @(negedge clk);
    start1 = 1'b0;
    waitIdle();

    // Reset during the second RUN cycle aborts without DONE
    @(negedge clk);
    a1 = 16'h1111; b1 = 16'h0001; ci1 = 1'b0; sub1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    nReset = 1'b0;
    #1;
    check("abort Q", 32'(q1), 32'd0);
    check("abort CO", 32'(co1), 32'd0);
    check("abort OV", 32'(ov1), 32'd0);
    check("abort BUSY", 32'(busy1), 32'd0);
    check("abort DONE", 32'(done1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    nReset = 1'b1;
    repeat (8) @(negedge clk);
    issue1("after abort 1234+0001", 16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0);
    waitIdle();

    // Single-chunk configuration
    issue2("c16 1234+4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    waitIdle();
    issue2("c16 sub 0003-0005", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    waitIdle();
    issue2("c16 7FFF+0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    waitIdle();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Multi-cycle, parametrised successor to the single-bit half adder.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, rippling the carry through a register between chunks.
- Trades latency for gate count in the Slipstream arithmetic paths, e.g. blitter address/step arithmetic where a full-width carry chain is too slow or too large.
- Start/busy/done handshake; result held until the next completion.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CHUNK, 4, bits processed per RUN cycle. WIDTH % CHUNK must be 0, otherwise elaboration fails.
- NCHUNK, WIDTH/CHUNK, derived localparam, not overridable.

Ports:
- MasterClock  in  1  system clock; all state on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- START  in  1  request; sampled only when BUSY=0.
- A  in  WIDTH  operand A; latched on accepted START.
- B  in  WIDTH  operand B; latched on accepted START.
- CI  in  1  carry-in; latched on accepted START; ignored when SUB=1.
- SUB  in  1  1 = A-B, 0 = A+B+CI; latched on accepted START.
- BUSY  out  1  high during RUN.
- DONE  out  1  single-cycle completion pulse.
- Q  out  WIDTH  registered result.
- CO  out  1  carry out of the MSB. When SUB=1, 1 means no borrow.
- OV  out  1  signed two's-complement overflow.

Behaviour:
- Reset, asynchronous, nReset=0:
  - state=IDLE, chunk counter=0, carry register=0, operand registers=0.
  - Q=0, CO=0, OV=0, BUSY=0, DONE=0.
  - Reset asserted mid-RUN aborts the operation; no DONE is produced.
- States: IDLE, RUN, FIN.
  - IDLE: on START=1:
    - latch A.
    - latch B, or ~B when SUB=1.
    - carry := SUB ? 1 : CI.
    - counter := 0.
    - go to RUN.
  - RUN: BUSY=1. Each cycle:
    - chunk k = counter covers bits [k*CHUNK +: CHUNK].
    - {c, s} = Aop[k] + Bop[k] + carry.
    - write s into the partial-sum register; carry := c.
    - if counter = NCHUNK-1, go to FIN; else counter++.
  - FIN: one cycle.
    - DONE=1, BUSY=0.
    - Q, CO and OV take the completed values on the edge entering FIN, so they are valid while DONE=1.
    - START=1 in FIN is accepted exactly as in IDLE (back-to-back, next state RUN). Otherwise go to IDLE.
- START while BUSY=1 is ignored; inputs are not sampled.
- Latency: accepted START edge to DONE high = NCHUNK+1 cycles. Throughput: one result per NCHUNK+1 cycles.
- CHUNK=WIDTH is legal: a single RUN cycle, latency 2.
- OV = carry into MSB XOR carry out of MSB. Captured in the final RUN cycle from the top chunk's internal carry.
- Q, CO and OV are stable except on the edge entering FIN.
- CI and SUB changes outside an accepted START have no effect.

Decomposition:
- Package slip_arith_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, FIN} csa_state_t.
  - function nchunk(width, chunk).
  - constant widths shared with other arithmetic blocks.
- One sub-module: chunk_full_add.
  - Combinational CHUNK-bit ripple adder built from half-adder cells.
  - Outputs the sum, the carry out, and the carry into the top bit (needed for OV).

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- Add, no carry: START with A=0x00FF, B=0x0001, CI=0, SUB=0 -> BUSY for 4 cycles; DONE on the 5th cycle; Q=0x0100, CO=0, OV=0.
- Wrap with carry: A=0xFFFF, B=0x0001, CI=0 -> Q=0x0000, CO=1, OV=0. Repeat with A=0x7FFF, B=0x0000, CI=1 -> Q=0x8000, CO=0, OV=1.
- Subtract with signed overflow: SUB=1, A=0x8000, B=0x0001, CI=1 (ignored) -> Q=0x7FFF, CO=1, OV=1.
- Handshake:
  - START pulses with new operands during RUN are ignored; the first result is unchanged.
  - START held in the FIN cycle with A=0x0002, B=0x0003 -> next DONE exactly 5 cycles later with Q=0x0005.
- Reset mid-operation: drop nReset on the 2nd RUN cycle -> Q, CO, OV, BUSY and DONE go to 0 immediately; no DONE after release; the next START completes normally.
- Configuration CHUNK=16: A=0x1234, B=0x4321 -> DONE 2 cycles after START; Q=0x5555, CO=0. A non-divisible config (WIDTH=16, CHUNK=5) fails elaboration.
